// File: rtl/ofm_packer.sv
// Packs four consecutive signed OFM elements into one output word, little-lane first.
// Frames of frame_len elements end with a zero-padded partial word flagged by out_last.
module ofm_packer #(
    parameter int OUTPUT_WIDTH     = 32,
    parameter int ofm_output_width = 8,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        frame_len,
    input  logic                        ofm_valid,
    input  logic [ofm_output_width-1:0] ofm_data,
    output logic                        ofm_ready,
    output logic                        out_valid,
    output logic [OUTPUT_WIDTH-1:0]     out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [OUTPUT_WIDTH-1:0] word_q, word_d;
    logic                    ofm_ready_q, out_valid_q, out_last_q, busy_q, done_q;
    logic                    accept_s;

    // ofm_ready_q is high exactly while the FSM sits in PACK
    assign accept_s = ofm_valid && ofm_ready_q;

    // Next-state, lane/remaining counters and word assembly
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d  = frame_len;
                    lane_d = 2'd0;
                    word_d = {OUTPUT_WIDTH{1'b0}};
                    if (frame_len != {LEN_WIDTH{1'b0}}) begin
                        state_d = PACK;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PACK: begin
                if (accept_s) begin
                    word_d[int'(lane_q) * ofm_output_width +: ofm_output_width] = ofm_data;
                    lane_d = lane_q + 2'd1;
                    rem_d  = rem_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                    if ((lane_q == 2'd3) || (rem_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1})) begin
                        state_d = SEND;
                    end else begin
                        state_d = PACK;
                    end
                end else begin
                    state_d = PACK;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (rem_q == {LEN_WIDTH{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = PACK;
                        lane_d  = 2'd0;
                        word_d  = {OUTPUT_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, word and registered output flags decoded from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            rem_q       <= {LEN_WIDTH{1'b0}};
            word_q      <= {OUTPUT_WIDTH{1'b0}};
            ofm_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            rem_q       <= rem_d;
            word_q      <= word_d;
            ofm_ready_q <= (state_d == PACK);
            out_valid_q <= (state_d == SEND);
            out_last_q  <= (state_d == SEND) && (rem_d == {LEN_WIDTH{1'b0}});
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign ofm_ready = ofm_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = word_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ofm_packer.sv
// Randomized scoreboard bench for ofm_packer: a frame-level model predicts packed words,
// a monitor pops and compares them on every output handshake.
module tb_ofm_packer;
    localparam int W  = 8;
    localparam int OW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          ofm_valid = 1'b0;
    logic [W-1:0]  ofm_data = '0;
    logic          out_ready = 1'b0;
    logic          ofm_ready, out_valid, out_last, busy, done;
    logic [OW-1:0] out_data;

    int total = 0;
    int bad   = 0;
    logic [OW-1:0] exp_data[$];
    bit            exp_last[$];
    logic [W-1:0]  el_q[$];

    ofm_packer #(.OUTPUT_WIDTH(OW), .ofm_output_width(W), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .ofm_valid(ofm_valid), .ofm_data(ofm_data), .ofm_ready(ofm_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: chunk elements by four, element k of a chunk weighted by 2^(8k)
    task automatic push_expected(input int len);
        for (int b = 0; b < len; b += 4) begin
            logic [OW-1:0] w = '0;
            for (int k = 0; k < 4; k++)
                if (b + k < len) w = w + (OW'(el_q[b+k]) << (8 * k));
            exp_data.push_back(w);
            exp_last.push_back(b + 4 >= len);
        end
    endtask

    // Monitor: word handshakes against the scoreboard, plus stall stability
    initial begin
        logic [OW-1:0] hold_data;
        logic          hold_last;
        bit            holding;
        holding = 0;
        forever begin
            @(negedge clk);
            if (holding && rst_n) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hold_data);
                check("stall_last", out_last, hold_last);
                check("stall_ofm_ready", ofm_ready, 0);
            end
            holding   = out_valid && !out_ready && rst_n;
            hold_data = out_data;
            hold_last = out_last;
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got %0h expected no word", out_data);
                end else begin
                    check("word_data", out_data, exp_data.pop_front());
                    check("word_last", out_last, exp_last.pop_front());
                end
            end
        end
    end

    // vmode: 0 = valid always, 1 = random; rmode: 0 = ready always, 1 = random, 2 = 5-cycle stall per word
    task automatic run_frame(input int len, input int vmode, input int rmode, input bit mid_start);
        int idx = 0, cyc = 0, busy_cyc = 0, stall = 0, dones = 0;
        bit seen_done = 0, exp_ov = 0;
        push_expected(len);
        @(posedge clk); #1;
        start = 1'b1; frame_len = LW'(len); ofm_valid = 1'b0; out_ready = 1'b1;
        while (!seen_done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (mid_start && busy && !done && $urandom_range(0, 3) == 0) begin
                start = 1'b1; frame_len = LW'(2);
            end
            ofm_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ofm_data  = (idx < len) ? el_q[idx] : W'($urandom);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!out_valid) stall = 0;
                    out_ready = !(out_valid && stall < 5);
                    if (out_valid && stall < 5) stall++;
                end
            endcase
            @(negedge clk);
            if (cyc == 1 && len > 0) check("first_ready", ofm_ready, 1);
            if (exp_ov) begin check("out_valid_latency", out_valid, 1); exp_ov = 0; end
            if (busy) busy_cyc++;
            if (ofm_valid && ofm_ready) begin
                idx++;
                if (idx % 4 == 0 || idx == len) exp_ov = 1;
            end
            if (done) begin seen_done = 1; dones++; end
        end
        start = 1'b0; ofm_valid = 1'b0;
        check("done_seen", seen_done, 1);
        check("accepted", idx, len);
        if (len == 0) begin
            check("zero_done_latency", cyc, 1);
            check("zero_busy_cycles", busy_cyc, 1);
        end
        @(negedge clk);
        if (done) dones++;
        check("done_pulses", dones, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic fill_random(input int len);
        el_q.delete();
        for (int i = 0; i < len; i++) el_q.push_back(W'($urandom));
    endtask

    initial begin
        int len;
        #1;
        check("rst_ofm_ready", ofm_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        el_q.delete();
        el_q.push_back(8'h01); el_q.push_back(8'h02); el_q.push_back(8'h03); el_q.push_back(8'hFF);
        run_frame(4, 0, 0, 0);

        el_q.delete();
        for (int i = 0; i < 6; i++) el_q.push_back(8'h11 + W'(i));
        run_frame(6, 0, 0, 0);

        el_q.delete();
        run_frame(0, 0, 0, 0);

        fill_random(8);
        run_frame(8, 0, 2, 0);

        fill_random(7);
        run_frame(7, 1, 1, 1);

        // Reset in the middle of a 4-element frame after two accepts
        begin
            int idx = 0, cyc = 0;
            fill_random(4);
            @(posedge clk); #1;
            start = 1'b1; frame_len = LW'(4);
            while (idx < 2 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
                start = 1'b0; ofm_valid = 1'b1; ofm_data = el_q[idx];
                @(negedge clk);
                if (ofm_valid && ofm_ready) idx++;
            end
            check("rst_mid_accepts", idx, 2);
            ofm_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("rst_mid_ofm_ready", ofm_ready, 0);
            check("rst_mid_out_valid", out_valid, 0);
            check("rst_mid_out_data", out_data, 0);
            check("rst_mid_out_last", out_last, 0);
            check("rst_mid_busy", busy, 0);
            check("rst_mid_done", done, 0);
            @(posedge clk); #1 rst_n = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                ofm_valid = 1'($urandom_range(0, 1)); out_ready = 1'b1;
                @(negedge clk);
                check("post_rst_quiet", {busy, done, out_valid}, 3'b000);
            end
            ofm_valid = 1'b0;
            fill_random(4);
            run_frame(4, 0, 0, 0);
        end

        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(0, 13);
            fill_random(len);
            run_frame(len, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_data.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofm_packer.md
OFM_PACKER -- requirements
Module: ofm_packer

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 32, output word width; SHALL equal 4*ofm_output_width.
REQ-002 Parameter ofm_output_width, default 8, OFM element width.
REQ-003 Parameter LEN_WIDTH, default 16, width of the frame-length field.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 frame_len  input  LEN_WIDTH  number of OFM elements in the frame; sampled on an honoured start.
REQ-008 ofm_valid  input  1  an OFM element is offered.
REQ-009 ofm_data  input  ofm_output_width  signed OFM element.
REQ-010 ofm_ready  output  1  packer accepts ofm_data this cycle.
REQ-011 out_valid  output  1  out_data holds a packed word.
REQ-012 out_data  output  OUTPUT_WIDTH  packed word toward MITO_output.
REQ-013 out_last  output  1  qualifies the final word of the frame.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at frame completion.

Function
REQ-017 FSM states SHALL be IDLE, PACK, SEND, DONE.
REQ-018 IDLE: start with frame_len>0 -> PACK; start with frame_len=0 -> DONE; otherwise stay in IDLE.
REQ-019 An element transfer SHALL occur on a cycle with ofm_valid && ofm_ready; ofm_ready SHALL be 1 only in PACK.
REQ-020 The k-th element of a word (k=0..3) SHALL be placed in bits [8k+7:8k]; element 0 goes in the LSBs, copied raw with no sign extension.
REQ-021 A 2-bit lane counter SHALL count accepted elements; a LEN_WIDTH remaining counter SHALL load frame_len on start and decrement on each accept.
REQ-022 PACK -> SEND on the cycle that accepts lane 3 or the last element of the frame (remaining=1).
REQ-023 A partial final word SHALL hold zeros in its unfilled upper lanes.
REQ-024 SEND: out_valid=1; out_last=1 only when remaining=0; out_data and out_last SHALL stay stable while out_valid && !out_ready.
REQ-025 SEND with out_ready=1: -> DONE when remaining=0, else -> PACK with lane counter and word register cleared.
REQ-026 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-027 Latency: the first element is acceptable in the cycle after start; out_valid SHALL rise in the cycle after the accept that completes a word.
REQ-028 Minimum throughput SHALL be one word per 5 cycles; ofm_ready=0 throughout SEND, with no skid buffer.
REQ-029 start while busy=1 SHALL be ignored, and frame_len SHALL NOT be resampled.
REQ-030 ofm_valid outside PACK SHALL have no effect; out_ready outside SEND SHALL have no effect.
REQ-031 out_valid, out_last, done SHALL NOT be asserted outside SEND/SEND/DONE respectively.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE with ofm_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, and both counters zero.
REQ-033 Reset mid-frame SHALL abandon the frame; no word or done pulse is produced after release until a new start.

Verification
REQ-034 start, frame_len=4, elements 0x01,0x02,0x03,0xFF back-to-back, out_ready=1 -> one word 0xFF030201 with out_last=1, then done one cycle later.
REQ-035 frame_len=6, elements 0x11..0x16 -> words 0x14131211 (out_last=0) and 0x00001615 (out_last=1).
REQ-036 frame_len=0 -> no out_valid, done pulse in the cycle after start, busy high for exactly 1 cycle.
REQ-037 out_ready held 0 for 5 cycles in SEND -> out_data/out_last stable, ofm_ready=0, no element lost when out_ready then rises.
REQ-038 start pulsed again mid-frame with frame_len=2, and ofm_valid toggled randomly -> original frame_len honoured, word count and contents match the model.
REQ-039 rst_n low after 2 of 4 elements -> outputs zero asynchronously; new frame_len=4 frame then yields a correct single word.
